// File: rtl/instr_encoder_loader.sv
// Symbolic-op to RV32I encoder that streams legal words into instruction memory.
// One registered imem write per accepted legal beat; illegal beats only raise err.
module instr_encoder_loader #(
  parameter int DEPTH     = 256,
  parameter int ADDR_W    = 8,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              finish,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_op,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [20:0]       in_imm,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   count
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [ADDR_W-1:0] BASE  = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W:0]   LIMIT = (ADDR_W+1)'(DEPTH);

  logic [1:0]        state;
  logic [ADDR_W-1:0] ptr;
  logic [31:0]       enc_word;
  logic              enc_legal;
  logic              fits_i;
  logic              fits_b;
  logic              accept;
  logic [ADDR_W:0]   count_inc;

  assign busy      = (state == ST_LOAD);
  assign done      = (state == ST_DONE);
  assign in_ready  = busy;
  assign accept    = in_valid & busy;
  assign count_inc = count + (ADDR_W+1)'(1);

  always_comb begin
    fits_i = ($signed(in_imm) >= -21'sd2048) && ($signed(in_imm) <= 21'sd2047);
    fits_b = ($signed(in_imm) >= -21'sd4096) && ($signed(in_imm) <= 21'sd4094) && !in_imm[0];
    enc_word  = 32'd0;
    enc_legal = 1'b1;
    case (in_op)
      4'd0: enc_word = {7'b0000000, in_rs2, in_rs1, 3'b000, in_rd, 7'b0110011};
      4'd1: enc_word = {7'b0100000, in_rs2, in_rs1, 3'b000, in_rd, 7'b0110011};
      4'd2: enc_word = {7'b0000000, in_rs2, in_rs1, 3'b111, in_rd, 7'b0110011};
      4'd3: enc_word = {7'b0000000, in_rs2, in_rs1, 3'b110, in_rd, 7'b0110011};
      4'd4: begin
        enc_word  = {in_imm[11:0], in_rs1, 3'b000, in_rd, 7'b0010011};
        enc_legal = fits_i;
      end
      4'd5: begin
        enc_word  = {in_imm[11:0], in_rs1, 3'b010, in_rd, 7'b0000011};
        enc_legal = fits_i;
      end
      4'd6: begin
        enc_word  = {in_imm[11:5], in_rs2, in_rs1, 3'b010, in_imm[4:0], 7'b0100011};
        enc_legal = fits_i;
      end
      4'd7: begin
        enc_word  = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, 3'b000,
                     in_imm[4:1], in_imm[11], 7'b1100011};
        enc_legal = fits_b;
      end
      4'd8: begin
        // Full 21-bit range is encodable; only alignment can fail.
        enc_word  = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, 7'b1101111};
        enc_legal = !in_imm[0];
      end
      4'd9: begin
        enc_word  = {in_imm[11:0], in_rs1, 3'b000, in_rd, 7'b1100111};
        enc_legal = fits_i;
      end
      default: begin
        enc_word  = 32'd0;
        enc_legal = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      ptr        <= BASE;
      imem_we    <= 1'b0;
      imem_addr  <= BASE;
      imem_wdata <= 32'd0;
      err        <= 1'b0;
      count      <= '0;
    end else begin
      imem_we <= 1'b0;
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state <= ST_LOAD;
            ptr   <= BASE;
            err   <= 1'b0;
            count <= '0;
          end
        end
        ST_LOAD: begin
          if (accept && enc_legal) begin
            imem_we    <= 1'b1;
            imem_addr  <= ptr;
            imem_wdata <= enc_word;
            ptr        <= ptr + ADDR_W'(1);
            count      <= count_inc;
          end
          if (accept && !enc_legal) begin
            err <= 1'b1;
          end
          // A beat arriving with finish, or filling the last slot, is written first.
          if (finish || (accept && enc_legal && (count_inc == LIMIT))) begin
            state <= ST_DONE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Scoreboard bench for instr_encoder_loader (DEPTH=4 so the capacity cap is reachable).
module tb_instr_encoder_loader;

  localparam int ADDR_W = 8;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic              finish = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [3:0]        in_op = 4'd0;
  logic [4:0]        in_rd = 5'd0;
  logic [4:0]        in_rs1 = 5'd0;
  logic [4:0]        in_rs2 = 5'd0;
  logic [20:0]       in_imm = 21'd0;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              busy;
  logic              done;
  logic              err;
  logic [ADDR_W:0]   count;

  int checks = 0;
  int failures = 0;
  logic [39:0] sb_q[$];
  logic [ADDR_W-1:0] exp_ptr = '0;

  instr_encoder_loader #(.DEPTH(4), .ADDR_W(ADDR_W), .BASE_ADDR(0)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .finish(finish),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_rd(in_rd),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .busy(busy), .done(done), .err(err), .count(count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end else begin
      $display("ok   %s = %0h", tag, got);
    end
  endtask

  // Write monitor: every imem write must match the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && imem_we) begin
      if (sb_q.size() == 0) begin
        check("unexpected_write", {24'd0, imem_addr, imem_wdata}, 64'd0);
      end else begin
        logic [39:0] e;
        e = sb_q.pop_front();
        check("wr_addr", 64'(imem_addr), 64'(e[39:32]));
        check("wr_data", 64'(imem_wdata), 64'(e[31:0]));
      end
    end
  end

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    exp_ptr = '0;
  endtask

  task automatic pulse_finish();
    @(posedge clk); #1 finish = 1'b1;
    @(posedge clk); #1 finish = 1'b0;
  endtask

  task automatic send(input logic [3:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                      input logic [4:0] rs2, input logic [20:0] imm, input bit legal,
                      input logic [31:0] word, input bit fin);
    int n;
    in_valid = 1'b1; in_op = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm;
    finish = fin;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      check("ready_timeout", 64'(in_ready), 64'd1);
    end else if (legal) begin
      sb_q.push_back({exp_ptr, word});
      exp_ptr = exp_ptr + 1'b1;
    end
    @(posedge clk); #1;
    in_valid = 1'b0; finish = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #2;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_ready", 64'(in_ready), 64'd0);
    check("rst_we", 64'(imem_we), 64'd0);
    check("rst_count", 64'(count), 64'd0);
    check("rst_wdata", 64'(imem_wdata), 64'd0);
    #10 rst_n = 1'b1;

    // Session A: ADD, ADDI, LW back to back
    pulse_start();
    check("a_busy", 64'(busy), 64'd1);
    send(4'd0, 5'd3, 5'd1, 5'd2, 21'd0, 1'b1, 32'h002081B3, 1'b0);
    send(4'd4, 5'd1, 5'd0, 5'd0, 21'd5, 1'b1, 32'h00500093, 1'b0);
    send(4'd5, 5'd5, 5'd2, 5'd0, 21'd8, 1'b1, 32'h00812283, 1'b0);
    check("a_count", 64'(count), 64'd3);
    pulse_finish();
    check("a_done", 64'(done), 64'd1);
    check("a_ready", 64'(in_ready), 64'd0);

    // Session B: branch/jump; finish arrives with the JAL beat
    pulse_start();
    check("b_count_clr", 64'(count), 64'd0);
    send(4'd7, 5'd0, 5'd1, 5'd2, 21'h1FFFFC, 1'b1, 32'hFE208EE3, 1'b0);
    send(4'd8, 5'd1, 5'd0, 5'd0, 21'd8, 1'b1, 32'h008000EF, 1'b1);
    check("b_done", 64'(done), 64'd1);
    check("b_count", 64'(count), 64'd2);

    // Session C: illegal beats, then legal ones at the unchanged address
    pulse_start();
    send(4'd4, 5'd1, 5'd0, 5'd0, 21'd2048, 1'b0, 32'd0, 1'b0);
    send(4'd7, 5'd0, 5'd1, 5'd2, 21'd3, 1'b0, 32'd0, 1'b0);
    send(4'd12, 5'd1, 5'd1, 5'd1, 21'd0, 1'b0, 32'd0, 1'b0);
    check("c_err", 64'(err), 64'd1);
    check("c_count0", 64'(count), 64'd0);
    send(4'd1, 5'd4, 5'd5, 5'd6, 21'd0, 1'b1, 32'h40628233, 1'b0);
    send(4'd6, 5'd9, 5'd2, 5'd3, 21'd12, 1'b1, 32'h00312623, 1'b0);
    send(4'd4, 5'd1, 5'd0, 5'd0, 21'h1FF800, 1'b1, 32'h80000093, 1'b0);
    check("c_err_sticky", 64'(err), 64'd1);
    check("c_count", 64'(count), 64'd3);
    pulse_finish();

    // Session D: fill to DEPTH, then a fifth beat must be held off
    pulse_start();
    check("d_err_clr", 64'(err), 64'd0);
    send(4'd2, 5'd7, 5'd1, 5'd2, 21'd0, 1'b1, 32'h0020F3B3, 1'b0);
    send(4'd3, 5'd1, 5'd2, 5'd3, 21'd0, 1'b1, 32'h003160B3, 1'b0);
    send(4'd9, 5'd0, 5'd1, 5'd0, 21'd0, 1'b1, 32'h00008067, 1'b0);
    send(4'd7, 5'd0, 5'd0, 5'd0, 21'd4094, 1'b1, 32'h7E000FE3, 1'b0);
    check("d_done", 64'(done), 64'd1);
    check("d_ready", 64'(in_ready), 64'd0);
    check("d_count", 64'(count), 64'd4);
    in_valid = 1'b1; in_op = 4'd0;
    repeat (3) @(posedge clk);
    #1 in_valid = 1'b0;
    check("d_held_count", 64'(count), 64'd4);

    // Session F: start ignored in LOAD, then async reset mid-session
    pulse_start();
    send(4'd0, 5'd3, 5'd1, 5'd2, 21'd0, 1'b1, 32'h002081B3, 1'b0);
    send(4'd15, 5'd0, 5'd0, 5'd0, 21'd0, 1'b0, 32'd0, 1'b0);
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    check("f_start_ignored", 64'(count), 64'd1);
    check("f_err", 64'(err), 64'd1);
    @(posedge clk); #3 rst_n = 1'b0;
    #1;
    check("f_rst_busy", 64'(busy), 64'd0);
    check("f_rst_ready", 64'(in_ready), 64'd0);
    check("f_rst_err", 64'(err), 64'd0);
    check("f_rst_count", 64'(count), 64'd0);
    check("f_rst_addr", 64'(imem_addr), 64'd0);
    check("f_rst_wdata", 64'(imem_wdata), 64'd0);
    @(negedge clk); rst_n = 1'b1;
    pulse_start();
    send(4'd4, 5'd1, 5'd0, 5'd0, 21'd5, 1'b1, 32'h00500093, 1'b0);
    check("f_count", 64'(count), 64'd1);
    pulse_finish();

    repeat (2) @(posedge clk);
    #1 check("sb_drain", 64'(sb_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
